store_data_unit: RTL
====================

# store_data_unit

Store-side data path between the MEM stage and the data-memory SRAM-like port. It is the narrowing counterpart of the load-side extension: it accepts a 32-bit store operand plus byte address and op, then replicates the byte or halfword across the bus. It generates byte strobes and size, checks alignment, and runs a one-outstanding-request handshake (req/addr_ok/data_ok) to memory. It holds one store in a single-entry buffer and back-pressures the pipeline through `st_ready`.

## Interface
Parameters:
- `ADDR_W`, 32, address width.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `st_valid`  in  1  store request from MEM stage.
- `st_ready`  out  1  unit can accept a store.
- `st_op`  in  2  00 SB, 01 SH, 10 SW, 11 reserved (treated as SW).
- `st_addr`  in  ADDR_W  byte address.
- `st_data`  in  32  rt register value; only the low 8/16/32 bits are used.
- `flush`  in  1  exception/eret flush from writeback.
- `st_done`  out  1  one-cycle pulse, store completed.
- `st_ades`  out  1  one-cycle pulse, misaligned store (macro only).
- `st_badvaddr`  out  ADDR_W  faulting address (macro only).
- `data_req`  out  1  memory request.
- `data_wr`  out  1  tied 1 while `data_req`.
- `data_size`  out  2  0 byte, 1 half, 2 word.
- `data_addr`  out  ADDR_W  request address.
- `data_wdata`  out  32  narrowed, replicated data.
- `data_wstrb`  out  4  byte enables.
- `data_addr_ok`  in  1  request accepted.
- `data_data_ok`  in  1  write committed.

## Operation
- FSM states:
  - IDLE: `st_ready`=1. `st_valid`&&`st_ready` captures op/addr/data into the buffer, then goes to REQ. A misaligned or flushed store instead stays in IDLE.
  - REQ: `data_req`=1 with all `data_*` registered and stable. `data_addr_ok` → WAIT. `flush` → IDLE with no request issued.
  - WAIT: `data_req`=0. `data_data_ok` → IDLE and `st_done` pulses, except when flushed.
- Narrowing:
  - SB: wdata={4{d[7:0]}}, wstrb=4'b0001<<addr[1:0], size 0.
  - SH: wdata={2{d[15:0]}}, wstrb=addr[1]?4'b1100:4'b0011, size 1.
  - SW/reserved: wdata=d, wstrb=4'b1111, size 2.
- `data_addr` carries the full byte address.
- `flush` in IDLE with `st_valid`: the store is not accepted.
- `flush` in WAIT: the write is already committed. The FSM still waits for `data_data_ok` but `st_done` is suppressed; a sticky flushed bit clears on return to IDLE.
- `data_data_ok` in IDLE or REQ is ignored (protocol forbids same-cycle addr_ok/data_ok).
- Reset (any state):
  - State returns to IDLE immediately.
  - Outputs reset to `data_req`=0, `st_done`=0, `st_ades`=0, `st_badvaddr`=0, and `data_*` buses=0.
  - A stale `data_data_ok` after reset is ignored.

## Timing
- Accept at cycle N → `data_req` at N+1.
- `data_addr_ok` at N+k (k≥1) → WAIT from N+k+1.
- `data_data_ok` at cycle M → `st_done`=1 and `st_ready`=1 at M+1.
- Minimum accept-to-done is 3 cycles.
- `st_ready` is combinational from state only, never from `st_valid`.
- Back-to-back stores: the next store can be accepted in the same cycle `st_done` is high.

## Configuration
- `STORE_ADDR_CHECK_EN` defined:
  - SH with addr[0]=1, or SW with addr[1:0]≠0, is accepted and dropped.
  - No memory request is issued.
  - `st_ades` pulses the cycle after accept, and `st_badvaddr` latches the address and holds it until the next fault.
  - `st_done` is not asserted.
- Not defined:
  - Ports `st_ades`/`st_badvaddr` are driven 0.
  - Address low bits are forced to zero (SH: bit 0; SW: bits 1:0) before strobe generation and `data_addr`.
  - No fault is ever flagged.

## Structure
- Package `store_pkg`:
  - op encodings `ST_SB`/`ST_SH`/`ST_SW`.
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`.
  - FSM state typedef (IDLE/REQ/WAIT).
- Sub-module `store_align`: purely combinational op+addr+data → wdata/wstrb/size/misaligned. Instantiated once, ahead of the buffer register.

## Test plan
- SB addr 0x1003 data 0x12345678, addr_ok at N+1, data_ok at N+3 → wdata 0x78787878, wstrb 1000, size 0, `st_done` at N+4.
- SH addr 0x2002 data 0xAAAA5A5A → wdata 0x5A5A5A5A, wstrb 1100, size 1. Holding addr_ok low 4 cycles keeps `data_req` and `data_*` stable throughout.
- SW addr 0x3001 with macro → no `data_req`, `st_ades` pulse, `st_badvaddr`=0x3001. Without macro → addr 0x3000, wstrb 1111, normal `st_done`.
- `flush` asserted in REQ before addr_ok → `data_req` drops next cycle and no `st_done`. `flush` asserted in WAIT → FSM waits for data_ok, `st_done` stays 0.
- Two back-to-back SWs with data_ok accepted on the `st_done` cycle → the second `data_req` follows with no bubble beyond the FSM minimum.
- `resetn` low in WAIT, then data_ok arrives after release → outputs at reset values, `st_done` stays 0, next store works normally.

Source files
------------

// File: rtl/store_pkg.sv
// Shared encodings for the store data path.
//   - Store op encodings as seen on st_op (11 is reserved and behaves as SW).
//   - Memory-side transfer size encodings driven on data_size.
//   - Store FSM state type.
package store_pkg;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } st_state_e;

endpackage

// File: rtl/store_align.sv
// Combinational store narrowing: replicates the byte/halfword across the
// 32-bit bus and produces byte strobes, transfer size and a misalignment flag.
//   op         in  2       store op (SB/SH/SW, 11 treated as SW)
//   addr       in  ADDR_W  byte address from the pipeline
//   data       in  32      store operand (low 8/16/32 bits used)
//   addr_out   out ADDR_W  address to present to memory
//   wdata      out 32      replicated write data
//   wstrb      out 4       byte enables
//   size       out 2       transfer size
//   misaligned out 1       unaligned SH/SW (only with the check enabled)
// Macro STORE_ADDR_CHECK_EN: when defined, unaligned SH/SW are flagged and the
// address passes through untouched; otherwise the low address bits are forced
// to zero for SH/SW and nothing is ever flagged.
module store_align
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data,
  output logic [ADDR_W-1:0] addr_out,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic [1:0]        size,
  output logic              misaligned
);

  always_comb begin
    addr_out   = addr;
    misaligned = 1'b0;
    case (op)
      ST_SB: begin
        wdata = {4{data[7:0]}};
        size  = SZ_BYTE;
      end
      ST_SH: begin
        wdata = {2{data[15:0]}};
        size  = SZ_HALF;
`ifdef STORE_ADDR_CHECK_EN
        misaligned = addr[0];
`else
        addr_out[0] = 1'b0;
`endif
      end
      default: begin
        wdata = data;
        size  = SZ_WORD;
`ifdef STORE_ADDR_CHECK_EN
        misaligned = |addr[1:0];
`else
        addr_out[1:0] = 2'b00;
`endif
      end
    endcase

    // Strobes come from the (possibly forced) address so they always match data_addr.
    case (op)
      ST_SB:   wstrb = 4'b0001 << addr_out[1:0];
      ST_SH:   wstrb = addr_out[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/store_data_unit.sv
// Store-side MEM-stage data path: narrows the store operand, buffers one store
// and runs a one-outstanding req/addr_ok/data_ok write handshake to memory.
//   clk, resetn              clock, asynchronous active-low reset
//   st_valid/st_ready        store handshake from MEM stage (ready = FSM idle)
//   st_op/st_addr/st_data    store op, byte address, operand
//   flush                    exception/eret flush
//   st_done                  one-cycle pulse when a store commits
//   st_ades/st_badvaddr      misaligned-store pulse and faulting address
//   data_req/data_wr         memory request (always a write)
//   data_size/addr/wdata/wstrb  registered request payload
//   data_addr_ok/data_data_ok   memory accept / commit
// Macro STORE_ADDR_CHECK_EN enables the alignment fault path; when undefined,
// st_ades/st_badvaddr are tied to 0 and unaligned addresses are forced aligned.
module store_data_unit
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_op,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic              flush,
  output logic              st_done,
  output logic              st_ades,
  output logic [ADDR_W-1:0] st_badvaddr,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok
);

  st_state_e         state_q, state_d;
  logic              flushed_q, flushed_d;
  logic              load_buf;
  logic              done_d;

  logic [ADDR_W-1:0] al_addr;
  logic [31:0]       al_wdata;
  logic [3:0]        al_wstrb;
  logic [1:0]        al_size;
  logic              al_misaligned;

  store_align #(.ADDR_W(ADDR_W)) u_align (
    .op         (st_op),
    .addr       (st_addr),
    .data       (st_data),
    .addr_out   (al_addr),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .size       (al_size),
    .misaligned (al_misaligned)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flushed_q <= flushed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    flushed_d = flushed_q;
    st_ready  = 1'b0;
    data_req  = 1'b0;
    load_buf  = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        st_ready  = 1'b1;
        flushed_d = 1'b0;
        if (st_valid && !flush && !al_misaligned) begin
          load_buf = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        data_req = 1'b1;
        // Once memory takes the request the write will commit, so a flush
        // arriving in the same cycle must still wait for data_ok.
        if (data_addr_ok) begin
          state_d   = WAIT;
          flushed_d = flush;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        flushed_d = flushed_q | flush;
        if (data_data_ok) begin
          state_d   = IDLE;
          flushed_d = 1'b0;
          done_d    = !(flushed_q || flush);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_done    <= 1'b0;
      data_size  <= '0;
      data_addr  <= '0;
      data_wdata <= '0;
      data_wstrb <= '0;
    end else begin
      st_done <= done_d;
      if (load_buf) begin
        data_size  <= al_size;
        data_addr  <= al_addr;
        data_wdata <= al_wdata;
        data_wstrb <= al_wstrb;
      end
    end
  end

  assign data_wr = data_req;

`ifdef STORE_ADDR_CHECK_EN
  logic fault;
  assign fault = (state_q == IDLE) && st_valid && !flush && al_misaligned;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_ades     <= 1'b0;
      st_badvaddr <= '0;
    end else begin
      st_ades <= fault;
      if (fault) st_badvaddr <= st_addr;
    end
  end
`else
  assign st_ades     = 1'b0;
  assign st_badvaddr = '0;
`endif

endmodule
